// File: rtl/picosoc_pkg.sv
// picosoc_pkg: register map, control bit indices and bus FSM encoding shared by the timer.
package picosoc_pkg;
  localparam logic [4:0] OFF_CTRL   = 5'h00;
  localparam logic [4:0] OFF_PRESC  = 5'h04;
  localparam logic [4:0] OFF_LOAD   = 5'h08;
  localparam logic [4:0] OFF_COUNT  = 5'h0C;
  localparam logic [4:0] OFF_STATUS = 5'h10;
  localparam int CTRL_EN     = 0;
  localparam int CTRL_RELOAD = 1;
  localparam int CTRL_IRQEN  = 2;
  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} bus_state_e;
  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] wdata, input logic [3:0] wstrb);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wstrb[i] ? wdata[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/picosoc_timer_core.sv
// picosoc_timer_core: prescaler and 32-bit down-counter with reload or one-shot expiry.
module picosoc_timer_core (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        reload,
  input  logic [15:0] presc,
  input  logic [31:0] load,
  input  logic        cnt_we,
  input  logic [31:0] cnt_wdata,
  output logic [31:0] count,
  output logic        expire,
  output logic        stop
);
  logic [15:0] pcnt;
  logic        tick;
  // >= keeps the prescaler from running away when PRESC is lowered below pcnt
  always_comb begin
    tick   = en && pcnt >= presc;
    expire = tick && !cnt_we && count == '0;
    stop   = expire && !reload;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pcnt  <= '0;
      count <= '0;
    end else begin
      pcnt  <= (!en || tick) ? '0 : pcnt + 16'd1;
      count <= cnt_we ? cnt_wdata : !tick ? count : count != '0 ? count - 32'd1 : reload ? load : count;
    end
endmodule

// File: rtl/picosoc_timer.sv
// picosoc_timer: native-bus timer with prescaler, reload/one-shot modes and a level irq.
module picosoc_timer
  import picosoc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'h0300_0000,
  parameter logic [15:0] DEFAULT_PRESC = 16'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        irq_out
);
  bus_state_e  state, state_nx;
  logic        sel, wr, clr, pend, pend_nx, expire, stop;
  logic [4:0]  woff;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q, rdata_q, wnew, load, count;
  logic [2:0]  ctrl, ctrl_nx;
  logic [15:0] presc;
  logic [31:0] regs [8];
  logic        unused_ok;
  assign unused_ok = &{1'b0, mem_addr[1:0]};
  always_comb begin
    regs    = '{default: '0};
    regs[0] = {29'd0, ctrl};
    regs[1] = {16'd0, presc};
    regs[2] = load;
    regs[3] = count;
    regs[4] = {31'd0, pend};
  end
  always_comb begin
    sel       = mem_valid && mem_addr[31:5] == BASE_ADDR[31:5];
    state_nx  = (state == IDLE && sel) ? ACK : IDLE;
    mem_ready = state == ACK;
    mem_rdata = mem_ready ? rdata_q : '0;
  end
  // Writes use the request captured at select and commit on the ACK cycle
  always_comb begin
    wr      = mem_ready && |wstrb_q;
    wnew    = merge_bytes(regs[woff[4:2]], wdata_q, wstrb_q);
    clr     = wr && woff == OFF_STATUS && wstrb_q[0] && wdata_q[0];
    pend_nx = expire || (pend && !clr);
    ctrl_nx = ctrl;
    if (stop) ctrl_nx[CTRL_EN] = 1'b0;
    if (wr && woff == OFF_CTRL) ctrl_nx = wnew[2:0];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= IDLE;
      woff    <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      ctrl    <= '0;
      presc   <= DEFAULT_PRESC;
      load    <= '0;
      pend    <= 1'b0;
      irq_out <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && sel) begin
        woff    <= {mem_addr[4:2], 2'b00};
        wdata_q <= mem_wdata;
        wstrb_q <= mem_wstrb;
        rdata_q <= regs[mem_addr[4:2]];
      end
      ctrl <= ctrl_nx;
      if (wr && woff == OFF_PRESC) presc <= wnew[15:0];
      if (wr && woff == OFF_LOAD) load <= wnew;
      pend    <= pend_nx;
      irq_out <= pend_nx && ctrl_nx[CTRL_IRQEN];
    end
  picosoc_timer_core u_core (
    .clk       (clk),
    .reset     (reset),
    .en        (ctrl[CTRL_EN]),
    .reload    (ctrl[CTRL_RELOAD]),
    .presc     (presc),
    .load      (load),
    .cnt_we    (wr && woff == OFF_COUNT),
    .cnt_wdata (wnew),
    .count     (count),
    .expire    (expire),
    .stop      (stop)
  );
endmodule

// File: tb/tb_picosoc_timer.sv
// tb_picosoc_timer: directed self-checking bench for picosoc_timer.
module tb_picosoc_timer;
  localparam logic [31:0] BASE = 32'h0300_0000;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        irq_out;
  int          n_asserts = 0;
  int          n_fail = 0;
  picosoc_timer #(.BASE_ADDR(BASE), .DEFAULT_PRESC(16'h1234)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .irq_out   (irq_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Bus tasks start and end 1 time unit after a rising edge
  task automatic bus_write(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s);
    mem_valid = 1'b1;
    mem_addr  = BASE | off;
    mem_wdata = d;
    mem_wstrb = s;
    @(posedge clk); #1;
    check("wr_ready", 32'(mem_ready), 32'd1);
    @(posedge clk); #1;
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    check("wr_ready_drop", 32'(mem_ready), 32'd0);
  endtask
  task automatic expect_rd(input string tag, input logic [31:0] off, input logic [31:0] exp);
    mem_valid = 1'b1;
    mem_addr  = BASE | off;
    mem_wdata = '0;
    mem_wstrb = 4'h0;
    @(posedge clk); #1;
    check({tag, "_ready"}, 32'(mem_ready), 32'd1);
    check(tag, mem_rdata, exp);
    @(posedge clk); #1;
    mem_valid = 1'b0;
    check({tag, "_idle_ready"}, 32'(mem_ready), 32'd0);
    check({tag, "_idle_rdata"}, mem_rdata, 32'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(mem_ready), 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_irq", 32'(irq_out), 32'd0);
    reset = 1'b0;
    expect_rd("rst_ctrl", 32'h00, 32'd0);
    expect_rd("rst_presc", 32'h04, 32'h0000_1234);
    expect_rd("rst_load", 32'h08, 32'd0);
    expect_rd("rst_count", 32'h0C, 32'd0);
    expect_rd("rst_status", 32'h10, 32'd0);
    expect_rd("rst_unimpl", 32'h14, 32'd0);
    // Outside the window: no acknowledge
    mem_valid = 1'b1;
    mem_addr  = BASE + 32'h20;
    @(posedge clk); #1;
    check("oow_ready0", 32'(mem_ready), 32'd0);
    @(posedge clk); #1;
    check("oow_ready1", 32'(mem_ready), 32'd0);
    mem_valid = 1'b0;
    bus_write(32'h1C, 32'hFFFF_FFFF, 4'hF);
    expect_rd("unimpl_wr", 32'h1C, 32'd0);
    expect_rd("unimpl_ctrl", 32'h00, 32'd0);
    // One-shot: PEND 4 edges after the CTRL commit edge
    bus_write(32'h04, 32'd0, 4'hF);
    bus_write(32'h0C, 32'd3, 4'hF);
    bus_write(32'h00, 32'h5, 4'hF);
    repeat (3) @(posedge clk);
    #1 check("os_irq_early", 32'(irq_out), 32'd0);
    @(posedge clk); #1;
    check("os_irq_set", 32'(irq_out), 32'd1);
    expect_rd("os_status", 32'h10, 32'd1);
    expect_rd("os_ctrl", 32'h00, 32'h4);
    expect_rd("os_count", 32'h0C, 32'd0);
    bus_write(32'h10, 32'd1, 4'hF);
    check("os_w1c_irq", 32'(irq_out), 32'd0);
    expect_rd("os_w1c_status", 32'h10, 32'd0);
    // Auto-reload: PRESC=1, LOAD=2 gives PEND every 6 cycles
    bus_write(32'h04, 32'd1, 4'hF);
    bus_write(32'h08, 32'd2, 4'hF);
    bus_write(32'h0C, 32'd2, 4'hF);
    bus_write(32'h00, 32'h7, 4'hF);
    repeat (5) @(posedge clk);
    #1 check("ar_irq_e5", 32'(irq_out), 32'd0);
    @(posedge clk); #1;
    check("ar_irq_e6", 32'(irq_out), 32'd1);
    bus_write(32'h10, 32'd1, 4'hF);
    check("ar_w1c_e8", 32'(irq_out), 32'd0);
    repeat (3) @(posedge clk);
    #1 check("ar_irq_e11", 32'(irq_out), 32'd0);
    @(posedge clk); #1;
    check("ar_irq_e12", 32'(irq_out), 32'd1);
    // W1C committed on edge 18, the same edge PEND sets again
    repeat (4) @(posedge clk);
    #1 bus_write(32'h10, 32'd1, 4'hF);
    check("col_w1c_irq", 32'(irq_out), 32'd1);
    expect_rd("col_w1c_status", 32'h10, 32'd1);
    // COUNT write against a tick every cycle
    bus_write(32'h00, 32'h0, 4'hF);
    bus_write(32'h04, 32'd0, 4'hF);
    bus_write(32'h08, 32'd100, 4'hF);
    bus_write(32'h00, 32'h3, 4'hF);
    bus_write(32'h0C, 32'd9, 4'hF);
    expect_rd("col_count", 32'h0C, 32'd9);
    bus_write(32'h00, 32'h0, 4'hF);
    // Byte strobes and width truncation
    bus_write(32'h08, 32'd0, 4'hF);
    bus_write(32'h08, 32'hAABB_CCDD, 4'b0101);
    expect_rd("strb_load", 32'h08, 32'h00BB_00DD);
    bus_write(32'h04, 32'hFFFF_ABCD, 4'hF);
    expect_rd("presc_width", 32'h04, 32'h0000_ABCD);
    bus_write(32'h00, 32'hFFFF_FFFF, 4'hF);
    expect_rd("ctrl_width", 32'h00, 32'h7);
    bus_write(32'h00, 32'h0, 4'hF);
    // Reset during the ACK cycle of a LOAD write
    mem_valid = 1'b1;
    mem_addr  = BASE | 32'h08;
    mem_wdata = 32'h1234_5678;
    mem_wstrb = 4'hF;
    @(posedge clk); #1;
    check("mid_ready_ack", 32'(mem_ready), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_ready_drop", 32'(mem_ready), 32'd0);
    check("mid_rdata", mem_rdata, 32'd0);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    @(posedge clk); #1;
    reset = 1'b0;
    expect_rd("mid_load", 32'h08, 32'd0);
    expect_rd("mid_presc", 32'h04, 32'h0000_1234);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/picosoc_timer.md
PICOSOC_TIMER -- requirements
Module: picosoc_timer

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0300_0000, meaning the 32-byte-aligned base of the register window.
REQ-002 The block SHALL have parameter DEFAULT_PRESC, default 16'd0, meaning the reset value of PRESC.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port mem_valid, input, 1 bit: CPU native-bus request valid.
REQ-006 The block SHALL have port mem_addr, input, 32 bits: byte address.
REQ-007 The block SHALL have port mem_wdata, input, 32 bits: write data.
REQ-008 The block SHALL have port mem_wstrb, input, 4 bits: byte write strobes; all zero means read.
REQ-009 The block SHALL have port mem_ready, output, 1 bit: transfer complete.
REQ-010 The block SHALL have port mem_rdata, output, 32 bits: read data, valid while mem_ready is high.
REQ-011 The block SHALL have port irq_out, output, 1 bit: level interrupt request toward a core irq bit.

Function
REQ-012 Select SHALL be: mem_valid && mem_addr[31:5]==BASE_ADDR[31:5].
REQ-013 The register map SHALL be: +0x00 CTRL[2:0] (bit0 EN, bit1 RELOAD, bit2 IRQEN); +0x04 PRESC[15:0]; +0x08 LOAD[31:0]; +0x0C COUNT[31:0]; +0x10 STATUS[0] (PEND, write-1-to-clear).
REQ-014 Bus FSM states SHALL be IDLE and ACK; IDLE->ACK on select; ACK->IDLE unconditionally.
REQ-015 mem_ready SHALL be high only in ACK, i.e. exactly one cycle, one cycle after select, and never two consecutive cycles.
REQ-016 Writes SHALL commit on the ACK cycle and honour each mem_wstrb byte lane; bits above a register's width SHALL be ignored.
REQ-017 Reads SHALL return registered data captured at select; unimplemented bits and offsets 0x14-0x1C SHALL read 0, and writes to those offsets SHALL be ignored but acknowledged.
REQ-018 mem_rdata SHALL be 0 whenever mem_ready is low.
REQ-019 The prescaler counter SHALL count 0..PRESC while EN=1 and emit one-cycle tick at PRESC; PRESC=0 SHALL give a tick every cycle.
REQ-020 EN=0 SHALL hold COUNT and clear the prescaler counter.
REQ-021 On tick with COUNT!=0, COUNT SHALL decrement by 1.
REQ-022 On tick with COUNT==0, PEND SHALL set, and COUNT SHALL load LOAD if RELOAD=1; otherwise EN SHALL clear (one-shot).
REQ-023 LOAD=0 with RELOAD=1 SHALL set PEND on every tick.
REQ-024 A COUNT write on the same cycle as a tick SHALL win; the tick is discarded.
REQ-025 A hardware PEND set on the same cycle as a W1C SHALL win; PEND stays 1.
REQ-026 A CTRL write on the same cycle as a one-shot EN clear SHALL win.
REQ-027 irq_out SHALL equal PEND && IRQEN, registered, with no extra latency beyond the PEND flop.
REQ-028 COUNT SHALL wrap only through reload and never underflow past 0.

Reset
REQ-029 On reset: FSM=IDLE, mem_ready=0, mem_rdata=0, irq_out=0, CTRL=0, PRESC=DEFAULT_PRESC, LOAD=0, COUNT=0, PEND=0, prescaler counter=0.
REQ-030 Reset asserted mid-transfer SHALL drop mem_ready immediately, and the write SHALL not commit.

Structure
REQ-031 Register offsets, CTRL bit indices and the FSM state encoding SHALL live in shared package picosoc_pkg.
REQ-032 The bus FSM and register file SHALL be in the top module; the prescaler and down-counter SHALL be one sub-module, picosoc_timer_core.

Verification
REQ-033 Bench SHALL cover read-after-reset: read CTRL, LOAD, COUNT, STATUS -> each 0; PRESC -> DEFAULT_PRESC; each mem_ready exactly 1 cycle after mem_valid.
REQ-034 Bench SHALL cover one-shot: PRESC=0, COUNT=3, CTRL=0x5 -> PEND and irq_out set 4 cycles after the write acks; EN reads 0.
REQ-035 Bench SHALL cover auto-reload: PRESC=1, LOAD=2, COUNT=2, CTRL=0x7 -> PEND every 6 cycles; W1C STATUS=1 clears irq_out the next cycle.
REQ-036 Bench SHALL cover byte strobes: write LOAD=0xAABBCCDD with wstrb=4'b0101 after LOAD=0 -> reads 0x00BB00DD.
REQ-037 Bench SHALL cover collisions: a W1C coincident with PEND set -> PEND stays 1; a COUNT=9 write coincident with a tick -> reads 9.
REQ-038 Bench SHALL cover reset mid-operation: assert reset during ACK of a LOAD write -> mem_ready=0 immediately; LOAD reads 0 after release.
